// File: rtl/hdmi_pattern_gen.sv
// Test-pattern pixel source for 640x480 HDMI: bars, checker, bouncing box, gradient.
// Ports: clk, reset_n (sync, active-low); timing-generator inputs disp_x/disp_y,
//   disp_active, frame_end, hsync_in, vsync_in, de_in; controls pattern_sel, pause;
//   outputs red/green/blue, hdmi_hsync/vsync/de (2-cycle aligned), frame_count.
// Optional: define PATTERN_BORDER_EN for a 1-pixel white frame border.
module hdmi_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_SIZE = 32,
  parameter int BOX_STEP = 2,
  parameter int COLOR_W  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [9:0]         disp_x,
  input  logic [9:0]         disp_y,
  input  logic               disp_active,
  input  logic               frame_end,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               de_in,
  input  logic [1:0]         pattern_sel,
  input  logic               pause,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               hdmi_hsync,
  output logic               hdmi_vsync,
  output logic               hdmi_de,
  output logic [7:0]         frame_count
);

  localparam logic [9:0]  BAR_W  = 10'(H_ACTIVE / 8);
  localparam logic [9:0]  STEP   = 10'(BOX_STEP);
  localparam logic [9:0]  X_MAX  = 10'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0]  X_TURN = 10'(H_ACTIVE - BOX_SIZE - BOX_STEP);
  localparam logic [9:0]  Y_MAX  = 10'(V_ACTIVE - BOX_SIZE);
  localparam logic [9:0]  Y_TURN = 10'(V_ACTIVE - BOX_SIZE - BOX_STEP);
  localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);

  localparam logic [COLOR_W-1:0] FULL = {COLOR_W{1'b1}};
  localparam logic [COLOR_W-1:0] GREY =
    {1'b1, {(COLOR_W-1){1'b0}}};

  logic [9:0] box_x;
  logic [9:0] box_y;
  logic       dir_left;
  logic       dir_up;
  logic [1:0] pat;

  // frame-rate state: pattern latch, counter, box motion
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      box_x       <= '0;
      box_y       <= '0;
      dir_left    <= 1'b0;
      dir_up      <= 1'b0;
      pat         <= 2'd0;
      frame_count <= 8'd0;
    end else if (frame_end) begin
      pat         <= pattern_sel;
      frame_count <= frame_count + 8'd1;
      if (!pause) begin
        if (!dir_left) begin
          if (box_x >= X_TURN) begin
            box_x    <= X_MAX;
            dir_left <= 1'b1;
          end else begin
            box_x <= box_x + STEP;
          end
        end else begin
          if (box_x <= STEP) begin
            box_x    <= '0;
            dir_left <= 1'b0;
          end else begin
            box_x <= box_x - STEP;
          end
        end
        if (!dir_up) begin
          if (box_y >= Y_TURN) begin
            box_y  <= Y_MAX;
            dir_up <= 1'b1;
          end else begin
            box_y <= box_y + STEP;
          end
        end else begin
          if (box_y <= STEP) begin
            box_y  <= '0;
            dir_up <= 1'b0;
          end else begin
            box_y <= box_y - STEP;
          end
        end
      end
    end
  end

  // stage 1: region classification
  logic [9:0] bar_q;
  logic       x_hit;
  logic       y_hit;

  assign bar_q = disp_x / BAR_W;
  assign x_hit = ({1'b0, disp_x} >= {1'b0, box_x}) &&
                 ({1'b0, disp_x} <  {1'b0, box_x} + BOX_W);
  assign y_hit = ({1'b0, disp_y} >= {1'b0, box_y}) &&
                 ({1'b0, disp_y} <  {1'b0, box_y} + BOX_W);

  logic       s1_act;
  logic       s1_hs;
  logic       s1_vs;
  logic       s1_de;
  logic [2:0] s1_bar;
  logic       s1_chk;
  logic       s1_box;
  logic [7:0] s1_gx;
  logic [7:0] s1_gy;
`ifdef PATTERN_BORDER_EN
  logic       s1_brd;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_act <= 1'b0;
      s1_hs  <= 1'b1;
      s1_vs  <= 1'b1;
      s1_de  <= 1'b0;
      s1_bar <= '0;
      s1_chk <= 1'b0;
      s1_box <= 1'b0;
      s1_gx  <= '0;
      s1_gy  <= '0;
`ifdef PATTERN_BORDER_EN
      s1_brd <= 1'b0;
`endif
    end else begin
      s1_act <= disp_active;
      s1_hs  <= hsync_in;
      s1_vs  <= vsync_in;
      s1_de  <= de_in;
      // x past the last bar only occurs outside the active area
      s1_bar <= (bar_q > 10'd7) ? 3'd7 : bar_q[2:0];
      s1_chk <= disp_x[5] ^ disp_y[5];
      s1_box <= x_hit && y_hit;
      s1_gx  <= disp_x[9:2];
      s1_gy  <= disp_y[8:1];
`ifdef PATTERN_BORDER_EN
      s1_brd <= (disp_x == 10'd0) ||
                (disp_x == 10'(H_ACTIVE - 1)) ||
                (disp_y == 10'd0) ||
                (disp_y == 10'(V_ACTIVE - 1));
`endif
    end
  end

  // stage 2: colour mux
  logic [2:0]         bar_m;
  logic [COLOR_W-1:0] r_n;
  logic [COLOR_W-1:0] g_n;
  logic [COLOR_W-1:0] b_n;

  always_comb begin
    bar_m = 3'b000;
    unique case (s1_bar)
      3'd0: bar_m = 3'b111;
      3'd1: bar_m = 3'b110;
      3'd2: bar_m = 3'b011;
      3'd3: bar_m = 3'b010;
      3'd4: bar_m = 3'b101;
      3'd5: bar_m = 3'b100;
      3'd6: bar_m = 3'b001;
      3'd7: bar_m = 3'b000;
    endcase
  end

  always_comb begin
    r_n = '0;
    g_n = '0;
    b_n = '0;
    if (s1_act) begin
      unique case (pat)
        2'd0: begin
          r_n = {COLOR_W{bar_m[2]}};
          g_n = {COLOR_W{bar_m[1]}};
          b_n = {COLOR_W{bar_m[0]}};
        end
        2'd1: begin
          if (s1_chk) begin
            r_n = FULL;
            g_n = FULL;
            b_n = FULL;
          end
        end
        2'd2: begin
          if (s1_box) begin
            r_n = GREY;
            g_n = GREY;
            b_n = GREY;
          end else begin
            r_n = {COLOR_W{bar_m[2]}};
            g_n = {COLOR_W{bar_m[1]}};
            b_n = {COLOR_W{bar_m[0]}};
          end
        end
        2'd3: begin
          r_n = COLOR_W'(s1_gx);
          g_n = COLOR_W'(s1_gy);
          b_n = COLOR_W'(frame_count);
        end
      endcase
`ifdef PATTERN_BORDER_EN
      if (s1_brd) begin
        r_n = FULL;
        g_n = FULL;
        b_n = FULL;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      hdmi_hsync <= 1'b1;
      hdmi_vsync <= 1'b1;
      hdmi_de    <= 1'b0;
    end else begin
      red        <= r_n;
      green      <= g_n;
      blue       <= b_n;
      hdmi_hsync <= s1_hs;
      hdmi_vsync <= s1_vs;
      hdmi_de    <= s1_de;
    end
  end

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Scoreboard bench for hdmi_pattern_gen.
// Drives pixels/frame pulses, predicts 2-cycle-late RGB/syncs.
module tb_hdmi_pattern_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] disp_x;
  logic [9:0] disp_y;
  logic       disp_active;
  logic       frame_end;
  logic       hsync_in;
  logic       vsync_in;
  logic       de_in;
  logic [1:0] pattern_sel;
  logic       pause;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       hdmi_hsync;
  logic       hdmi_vsync;
  logic       hdmi_de;
  logic [7:0] frame_count;

  always #5 clk = ~clk;

  hdmi_pattern_gen dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .disp_x      (disp_x),
    .disp_y      (disp_y),
    .disp_active (disp_active),
    .frame_end   (frame_end),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .de_in       (de_in),
    .pattern_sel (pattern_sel),
    .pause       (pause),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .hdmi_hsync  (hdmi_hsync),
    .hdmi_vsync  (hdmi_vsync),
    .hdmi_de     (hdmi_de),
    .frame_count (frame_count)
  );

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  int         m_bx;
  int         m_by;
  bit         m_left;
  bit         m_up;
  logic [1:0] m_pat;
  logic [7:0] m_fc;

  logic [23:0] bars [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic logic [23:0] pix(int x, int y,
                                      bit act, bit ib);
    logic [9:0]  xv;
    logic [9:0]  yv;
    logic [23:0] c;
    xv = 10'(x);
    yv = 10'(y);
    c = 24'h0;
    if (act) begin
      case (m_pat)
        2'd0: c = bars[x / 80];
        2'd1: c = (((x / 32) + (y / 32)) % 2 == 1) ?
                  24'hFFFFFF : 24'h0;
        2'd2: c = ib ? 24'h808080 : bars[x / 80];
        default: c = {xv[9:2], yv[8:1], m_fc};
      endcase
`ifdef PATTERN_BORDER_EN
      if (x == 0 || x == 639 || y == 0 || y == 479)
        c = 24'hFFFFFF;
`endif
    end
    return c;
  endfunction

  task automatic move();
    if (!m_left) begin
      if (m_bx >= 606) begin m_bx = 608; m_left = 1; end
      else m_bx += 2;
    end else begin
      if (m_bx <= 2) begin m_bx = 0; m_left = 0; end
      else m_bx -= 2;
    end
    if (!m_up) begin
      if (m_by >= 446) begin m_by = 448; m_up = 1; end
      else m_by += 2;
    end else begin
      if (m_by <= 2) begin m_by = 0; m_up = 0; end
      else m_by -= 2;
    end
  endtask

  task automatic step(input int x, input int y,
                      input bit act, input bit fe,
                      input bit hs, input bit vs,
                      input bit de);
    exp_t e;
    bit   ib;
    disp_x      = 10'(x);
    disp_y      = 10'(y);
    disp_active = act;
    frame_end   = fe;
    hsync_in    = hs;
    vsync_in    = vs;
    de_in       = de;
    ib = (x >= m_bx) && (x < m_bx + 32) &&
         (y >= m_by) && (y < m_by + 32);
    if (fe) begin
      m_pat = pattern_sel;
      m_fc  = m_fc + 8'd1;
      if (!pause) move();
    end
    e.rgb = pix(x, y, act, ib);
    e.hs  = hs;
    e.vs  = vs;
    e.de  = de;
    q.push_back(e);
    @(negedge clk);
    e = q.pop_front();
    chk("rgb", {red, green, blue}, e.rgb);
    chk("hsync", hdmi_hsync, e.hs);
    chk("vsync", hdmi_vsync, e.vs);
    chk("de", hdmi_de, e.de);
    chk("frame_count", frame_count, m_fc);
  endtask

  task automatic pixel(input int x, input int y);
    step(x, y, 1, 0, 1, 1, 1);
  endtask

  task automatic pulse();
    step(640, 480, 0, 1, 1, 1, 0);
  endtask

  task automatic probe_box();
    pixel(m_bx, m_by);
    pixel(m_bx + 31, m_by + 31);
    if (m_bx + 32 < 640) pixel(m_bx + 32, m_by);
    if (m_bx > 0) pixel(m_bx - 1, m_by);
    if (m_by > 0) pixel(m_bx, m_by - 1);
  endtask

  task automatic do_reset();
    exp_t r;
    reset_n     = 1'b0;
    frame_end   = 1'b1;
    hsync_in    = 1'b0;
    vsync_in    = 1'b0;
    de_in       = 1'b1;
    disp_active = 1'b1;
    disp_x      = 10'd100;
    disp_y      = 10'd100;
    repeat (3) begin
      @(negedge clk);
      chk("rst_rgb", {red, green, blue}, 24'h0);
      chk("rst_hsync", hdmi_hsync, 1'b1);
      chk("rst_vsync", hdmi_vsync, 1'b1);
      chk("rst_de", hdmi_de, 1'b0);
      chk("rst_fc", frame_count, 8'd0);
    end
    m_bx = 0; m_by = 0; m_left = 0; m_up = 0;
    m_pat = 2'd0; m_fc = 8'd0;
    q.delete();
    r.rgb = 24'h0; r.hs = 1'b1; r.vs = 1'b1; r.de = 1'b0;
    q.push_back(r);
    reset_n   = 1'b1;
    frame_end = 1'b0;
  endtask

  logic [7:0] fc0;

  initial begin
    pattern_sel = 2'd0;
    pause       = 1'b0;
    do_reset();

    pixel(79, 10);
    pixel(80, 10);
    pixel(639, 10);
    for (int i = 0; i < 8; i++) pixel(i * 80 + 40, 10);
    step(200, 10, 0, 0, 1, 1, 0);

    step(300, 20, 1, 0, 0, 1, 1);
    step(301, 20, 1, 0, 1, 0, 1);
    step(302, 20, 1, 0, 1, 1, 0);
    step(303, 20, 1, 0, 1, 1, 1);

    pattern_sel = 2'd1;
    pixel(40, 10);
    pixel(32, 0);
    pulse();
    pixel(5, 5);
    pixel(32, 5);
    pixel(32, 32);
    pixel(100, 70);

    pattern_sel = 2'd3;
    for (int i = 0; i < 10 && m_fc != 8'd7; i++) pulse();
    pixel(400, 200);
    pixel(639, 479);
    pixel(3, 511);

    pattern_sel = 2'd2;
    pause = 1'b1;
    pulse();
    probe_box();
    fc0 = frame_count;
    repeat (5) pulse();
    chk("pause_fc", frame_count, fc0 + 8'd5);
    probe_box();

    pause = 1'b0;
    repeat (700) begin
      pulse();
      probe_box();
    end

    pixel(10, 10);
    do_reset();
    pause = 1'b1;
    pulse();
    pixel(0, 0);
    pixel(31, 31);
    pixel(32, 0);
    pixel(0, 32);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
